// File: rtl/linear_layer_fifo_pkg.sv
// Shared sizing helpers for the linear-layer SRL FIFOs.
// Counters span 0..DEPTH+1 because the output register holds one extra token.
package linear_layer_fifo_pkg;

    localparam int OUT_REG_SLOTS = 1;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int fifo_cap(input int depth);
        return depth + OUT_REG_SLOTS;
    endfunction

endpackage

// File: rtl/srl_fifo_storage.sv
// SRL-style shift array: writes enter slot 0 and push older entries up one slot.
// The read port is combinational so the control can sample the oldest entry pre-shift.
module srl_fifo_storage
    import linear_layer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Shift register chain, intentionally without reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_r[i] <= mem_r[i-1];
            end
        end
    end

    // Out-of-range addresses only occur when the SRL is empty and are don't-care.
    always_comb begin
        if (int'(addr) < DEPTH) begin
            dout = mem_r[addr];
        end else begin
            dout = '0;
        end
    end

endmodule

// File: rtl/linear_layer_srl_fifo_rd.sv
// ap_fifo channel for linear-layer dataflow tokens: SRL storage plus a
// first-word-fall-through output register that holds the head token.
module linear_layer_srl_fifo_rd
    import linear_layer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic [ADDR_WIDTH:0]   if_fifo_cap
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CAP_C   = CNT_W'(fifo_cap(DEPTH));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]      srl_cnt_r;
    logic [CNT_W-1:0]      srl_cnt_nxt_s;
    logic                  dout_valid_r;
    logic                  dout_valid_nxt_s;
    logic                  full_n_r;
    logic [CNT_W-1:0]      num_valid_r;
    logic [DATA_WIDTH-1:0] dout_r;
    logic                  push_s;
    logic                  rd_s;
    logic                  pop_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;
    logic [DATA_WIDTH-1:0] storage_q_s;

    srl_fifo_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk  (clk),
        .we   (push_s),
        .din  (if_din),
        .addr (rd_addr_s),
        .dout (storage_q_s)
    );

    // Handshake qualification and the pre-shift read address of the oldest entry.
    always_comb begin
        push_s    = if_write & if_write_ce & full_n_r;
        rd_s      = if_read & if_read_ce & dout_valid_r;
        pop_s     = (srl_cnt_r != '0) & (~dout_valid_r | rd_s);
        rd_addr_s = ADDR_WIDTH'(srl_cnt_r - CNT_ONE);
    end

    // Next occupancy and output-register validity.
    always_comb begin
        srl_cnt_nxt_s    = srl_cnt_r;
        dout_valid_nxt_s = dout_valid_r;
        case ({push_s, pop_s})
            2'b10:   srl_cnt_nxt_s = srl_cnt_r + CNT_ONE;
            2'b01:   srl_cnt_nxt_s = srl_cnt_r - CNT_ONE;
            default: srl_cnt_nxt_s = srl_cnt_r;
        endcase
        if (pop_s) begin
            dout_valid_nxt_s = 1'b1;
        end else if (rd_s) begin
            dout_valid_nxt_s = 1'b0;
        end else begin
            dout_valid_nxt_s = dout_valid_r;
        end
    end

    // Control state, output register and flags; flags are pre-decoded from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            srl_cnt_r    <= '0;
            dout_valid_r <= 1'b0;
            full_n_r     <= 1'b1;
            num_valid_r  <= '0;
            dout_r       <= '0;
        end else begin
            srl_cnt_r    <= srl_cnt_nxt_s;
            dout_valid_r <= dout_valid_nxt_s;
            full_n_r     <= (srl_cnt_nxt_s != DEPTH_C);
            num_valid_r  <= srl_cnt_nxt_s + CNT_W'(dout_valid_nxt_s);
            if (pop_s) begin
                dout_r <= storage_q_s;
            end else begin
                dout_r <= dout_r;
            end
        end
    end

    assign if_full_n         = full_n_r;
    assign if_empty_n        = dout_valid_r;
    assign if_dout           = dout_r;
    assign if_num_data_valid = num_valid_r;
    assign if_fifo_cap       = CAP_C;

endmodule

// File: tb/tb_linear_layer_srl_fifo_rd.sv
// Scoreboard bench for linear_layer_srl_fifo_rd with DEPTH=2, DATA_WIDTH=8.
module tb_linear_layer_srl_fifo_rd;

    localparam int DW    = 8;
    localparam int AW    = 1;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_full_n;
    logic          if_write_ce;
    logic          if_write;
    logic [DW-1:0] if_din;
    logic          if_empty_n;
    logic          if_read_ce;
    logic          if_read;
    logic [DW-1:0] if_dout;
    logic [AW:0]   if_num_data_valid;
    logic [AW:0]   if_fifo_cap;

    int            tests = 0;
    int            fails = 0;
    int            m_srl = 0;
    bit            m_valid = 1'b0;
    int            rd_total = 0;
    logic [DW-1:0] sb[$];

    linear_layer_srl_fifo_rd #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .if_full_n         (if_full_n),
        .if_write_ce       (if_write_ce),
        .if_write          (if_write),
        .if_din            (if_din),
        .if_empty_n        (if_empty_n),
        .if_read_ce        (if_read_ce),
        .if_read           (if_read),
        .if_dout           (if_dout),
        .if_num_data_valid (if_num_data_valid),
        .if_fifo_cap       (if_fifo_cap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation budget expired, got no finish, required finish");
        $fatal(1, "timeout");
    end

    // One clock cycle: drive inputs, predict accept/pop, compare popped data and flags.
    task automatic step(input logic w, input logic wce, input logic [DW-1:0] d,
                        input logic r, input logic rce);
        bit            push, rd, pop;
        logic [DW-1:0] exp;
        if_write    = w;
        if_write_ce = wce;
        if_din      = d;
        if_read     = r;
        if_read_ce  = rce;
        push = w && wce && (m_srl != DEPTH);
        rd   = r && rce && m_valid;
        pop  = (m_srl != 0) && (!m_valid || rd);
        if (rd) begin
            exp = sb.pop_front();
            rd_total++;
            tests++;
            if (if_dout !== exp) begin
                fails++;
                $display("FAIL read_data: got %02h, required %02h", if_dout, exp);
            end
        end
        if (push) sb.push_back(d);
        if (push && !pop) m_srl++;
        else if (pop && !push) m_srl--;
        if (pop) m_valid = 1'b1;
        else if (rd) m_valid = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if ({if_empty_n, if_full_n, if_num_data_valid} !==
            {m_valid, (m_srl != DEPTH), 2'(m_srl + int'(m_valid))}) begin
            fails++;
            $display("FAIL flags: got empty_n=%0b full_n=%0b cnt=%0d, required %0b %0b %0d",
                     if_empty_n, if_full_n, if_num_data_valid,
                     m_valid, (m_srl != DEPTH), m_srl + int'(m_valid));
        end
        if (m_valid) begin
            tests++;
            if (if_dout !== sb[0]) begin
                fails++;
                $display("FAIL head: got %02h, required %02h", if_dout, sb[0]);
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        tests++;
        if ({if_full_n, if_empty_n, if_dout, if_num_data_valid, if_fifo_cap} !==
            {1'b1, 1'b0, 8'h00, 2'd0, 2'd3}) begin
            fails++;
            $display("FAIL reset_state: got full_n=%0b empty_n=%0b dout=%02h cnt=%0d cap=%0d, required 1 0 00 0 3",
                     if_full_n, if_empty_n, if_dout, if_num_data_valid, if_fifo_cap);
        end
        idle();
    endtask

    task automatic test_single();
        step(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        idle();
        tests++;
        if (if_empty_n !== 1'b1 || if_dout !== 8'hA5) begin
            fails++;
            $display("FAIL single_latency: got empty_n=%0b dout=%02h, required 1 a5", if_empty_n, if_dout);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tests++;
        if (if_empty_n !== 1'b0 || if_num_data_valid !== 2'd0) begin
            fails++;
            $display("FAIL single_drain: got empty_n=%0b cnt=%0d, required 0 0", if_empty_n, if_num_data_valid);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
        tests++;
        if (if_full_n !== 1'b0 || if_num_data_valid !== 2'd3) begin
            fails++;
            $display("FAIL fill: got full_n=%0b cnt=%0d, required 0 3", if_full_n, if_num_data_valid);
        end
        step(1'b1, 1'b1, 8'h04, 1'b0, 1'b0);
        tests++;
        if (if_num_data_valid !== 2'd3 || if_dout !== 8'h01) begin
            fails++;
            $display("FAIL overflow_ignored: got cnt=%0d dout=%02h, required 3 01", if_num_data_valid, if_dout);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tests++;
        if (if_empty_n !== 1'b0) begin
            fails++;
            $display("FAIL fill_drain: got empty_n=%0b, required 0", if_empty_n);
        end
    endtask

    task automatic test_back_to_back();
        int rd_start;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        rd_start = rd_total;
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 8'(8'h13 + i), 1'b1, 1'b1);
        tests++;
        if (rd_total - rd_start !== 100) begin
            fails++;
            $display("FAIL stream_reads: got %0d reads, required 100", rd_total - rd_start);
        end
        while (m_valid) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_ce_gating();
        step(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
        tests++;
        if (if_num_data_valid !== 2'd1 || if_dout !== 8'h3C || if_empty_n !== 1'b1) begin
            fails++;
            $display("FAIL ce_gating: got cnt=%0d dout=%02h empty_n=%0b, required 1 3c 1",
                     if_num_data_valid, if_dout, if_empty_n);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_reset_midop();
        step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if ({if_full_n, if_empty_n, if_dout, if_num_data_valid} !== {1'b1, 1'b0, 8'h00, 2'd0}) begin
            fails++;
            $display("FAIL async_reset: got full_n=%0b empty_n=%0b dout=%02h cnt=%0d, required 1 0 00 0",
                     if_full_n, if_empty_n, if_dout, if_num_data_valid);
        end
        sb.delete();
        m_srl   = 0;
        m_valid = 1'b0;
        #1;
        reset = 1'b0;
        step(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        idle();
        tests++;
        if (if_empty_n !== 1'b1 || if_dout !== 8'h5A) begin
            fails++;
            $display("FAIL post_reset: got empty_n=%0b dout=%02h, required 1 5a", if_empty_n, if_dout);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    initial begin
        reset       = 1'b1;
        if_write    = 1'b0;
        if_write_ce = 1'b0;
        if_din      = 8'h00;
        if_read     = 1'b0;
        if_read_ce  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_back_to_back();
        test_ce_gating();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
